// File: rtl/bus_arbiter_5.sv
// Round-robin arbiter for the shared five-input bus mux.
// Grants one requester at a time for a burst. A burst ends on the owner's last
// beat, when the owner withdraws its request, or when it reaches MAX_BURST cycles.
module bus_arbiter_5 #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned TURNAROUND = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] req,
  input  logic [4:0] last,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic       preempt
);

  localparam int unsigned N  = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [SW-1:0]   ptr_q, ptr_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [N-1:0]    grant_n;
  logic [SW-1:0]   sel_n;
  logic            valid_n;
  logic            preempt_n;

  logic [SW:0]     pick_any;
  logic [SW:0]     pick_oth;
  logic            owner_req;
  logic            owner_last;
  logic            timeout;
  logic            load;
  logic [SW-1:0]   win;

  // First asserted request scanning p, p+1, ... modulo N; MSB flags a hit.
  function automatic logic [SW:0] pick(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic [SW:0]  res;
    int unsigned  idx;
    res = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(p) + i;
      if (idx >= N) idx = idx - N;
      if (!res[SW] && r[SW'(idx)]) res = {1'b1, SW'(idx)};
    end
    return res;
  endfunction

  // State, pointer, burst counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      sel       <= '0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      grant     <= grant_n;
      sel       <= sel_n;
      bus_valid <= valid_n;
      preempt   <= preempt_n;
    end
  end

  // Next-state, release decision and winner selection.
  always_comb begin
    state_n    = state_q;
    ptr_n      = ptr_q;
    cnt_n      = cnt_q;
    grant_n    = grant;
    sel_n      = sel;
    valid_n    = bus_valid;
    preempt_n  = 1'b0;
    load       = 1'b0;
    win        = '0;

    pick_any   = pick(req, ptr_q);
    // The released owner is masked so it cannot immediately re-win a handover.
    pick_oth   = pick(req & ~grant, ptr_q);
    owner_req  = |(req & grant);
    owner_last = |(last & grant);
    timeout    = (cnt_q == CW'(MAX_BURST));

    case (state_q)
      IDLE, TURN: begin
        if (pick_any[SW]) begin
          load = 1'b1;
          win  = pick_any[SW-1:0];
        end else begin
          state_n = IDLE;
          grant_n = '0;
          sel_n   = '0;
          valid_n = 1'b0;
        end
      end
      BUSY: begin
        if (!owner_req || owner_last || timeout) begin
          // Only a pure timeout (owner still requesting, no last beat) preempts.
          preempt_n = owner_req && !owner_last;
          if (TURNAROUND != 0) begin
            state_n = TURN;
            grant_n = '0;
            sel_n   = '0;
            valid_n = 1'b0;
          end else if (pick_oth[SW]) begin
            load = 1'b1;
            win  = pick_oth[SW-1:0];
          end else begin
            state_n = IDLE;
            grant_n = '0;
            sel_n   = '0;
            valid_n = 1'b0;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        sel_n   = '0;
        valid_n = 1'b0;
      end
    endcase

    // Start a new burst for the chosen winner.
    if (load) begin
      state_n = BUSY;
      grant_n = N'(1) << win;
      sel_n   = win;
      valid_n = 1'b1;
      cnt_n   = CW'(1);
      ptr_n   = (win == SW'(N - 1)) ? '0 : win + SW'(1);
    end
  end

endmodule

// File: tb/tb_bus_arbiter_5.sv
// Testbench for bus_arbiter_5: three parameterisations driven in parallel,
// each compared every cycle against a behavioural model of the arbitration rules.
module tb_bus_arbiter_5;

  logic            clock;
  logic            reset_n;
  logic [4:0]      req;
  logic [4:0]      last;
  logic [2:0][4:0] g;
  logic [2:0][2:0] s;
  logic [2:0]      v;
  logic [2:0]      pr;

  int mb[3] = '{16, 4, 3};
  int ta[3] = '{0, 0, 1};

  int m_owner[3];
  int m_ptr[3];
  int m_cnt[3];
  bit m_pre[3];

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_ta[5] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00001};

  bus_arbiter_5 #(.MAX_BURST(16), .TURNAROUND(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last),
    .grant(g[0]), .sel(s[0]), .bus_valid(v[0]), .preempt(pr[0]));

  bus_arbiter_5 #(.MAX_BURST(4), .TURNAROUND(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last),
    .grant(g[1]), .sel(s[1]), .bus_valid(v[1]), .preempt(pr[1]));

  bus_arbiter_5 #(.MAX_BURST(3), .TURNAROUND(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .req(req), .last(last),
    .grant(g[2]), .sel(s[2]), .bus_valid(v[2]), .preempt(pr[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // First requester at or after position p (mod 5), skipping excl; -1 if none.
  function automatic int first_req(input logic [4:0] r, input int p, input int excl);
    int j;
    for (int i = 0; i < 5; i++) begin
      j = (p + i) % 5;
      if (r[j[2:0]] && j != excl) return j;
    end
    return -1;
  endfunction

  // Advance the reference model by one clock edge.
  task automatic model_update(input logic [4:0] r, input logic [4:0] l, input logic rn);
    int w;
    int o;
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        m_owner[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_pre[k] = 1'b0;
      end else begin
        m_pre[k] = 1'b0;
        if (m_owner[k] < 0) begin
          w = first_req(r, m_ptr[k], -1);
          if (w >= 0) begin
            m_owner[k] = w; m_ptr[k] = (w + 1) % 5; m_cnt[k] = 1;
          end
        end else begin
          o = m_owner[k];
          if (!r[o[2:0]] || l[o[2:0]] || m_cnt[k] == mb[k]) begin
            m_pre[k]   = r[o[2:0]] && !l[o[2:0]];
            m_owner[k] = -1;
            if (ta[k] == 0) begin
              w = first_req(r, m_ptr[k], o);
              if (w >= 0) begin
                m_owner[k] = w; m_ptr[k] = (w + 1) % 5; m_cnt[k] = 1;
              end
            end
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every instance against the model.
  task automatic check_all();
    logic [4:0] eg;
    logic [2:0] es;
    logic       ev;
    for (int k = 0; k < 3; k++) begin
      eg = '0; es = '0; ev = 1'b0;
      if (m_owner[k] >= 0) begin
        eg = 5'd1 << m_owner[k];
        es = 3'(m_owner[k]);
        ev = 1'b1;
      end
      chk($sformatf("grant_dut%0d", k),   8'(g[k]),  8'(eg));
      chk($sformatf("sel_dut%0d", k),     8'(s[k]),  8'(es));
      chk($sformatf("valid_dut%0d", k),   8'(v[k]),  8'(ev));
      chk($sformatf("preempt_dut%0d", k), 8'(pr[k]), 8'(m_pre[k]));
    end
  endtask

  // Apply inputs for one cycle, advance the model at the edge, then check.
  task automatic step(input logic [4:0] r, input logic [4:0] l, input logic rn);
    req = r; last = l; reset_n = rn;
    @(posedge clock);
    model_update(r, l, rn);
    #1;
    check_all();
  endtask

  initial begin
    logic [4:0] rr;
    logic [4:0] rl;
    logic       rn;
    reset_n = 1'b0; req = '0; last = '0;
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_pre[k] = 1'b0;
    end

    // reset state
    step(5'b0, 5'b0, 1'b0);
    step(5'b0, 5'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_grant", 8'(g[k]), 8'h00);
      chk("rst_sel", 8'(s[k]), 8'h00);
      chk("rst_valid", 8'(v[k]), 8'h00);
      chk("rst_preempt", 8'(pr[k]), 8'h00);
    end

    // single requester with last on the third granted cycle
    step(5'b00100, 5'b0, 1'b1);
    chk("single_grant", 8'(g[0]), 8'h04);
    chk("single_sel", 8'(s[0]), 8'h02);
    chk("single_valid", 8'(v[0]), 8'h01);
    step(5'b00100, 5'b0, 1'b1);
    step(5'b00100, 5'b0, 1'b1);
    step(5'b00100, 5'b00100, 1'b1);
    chk("single_release", 8'(g[0]), 8'h00);
    chk("last_and_timeout_no_preempt", 8'(pr[2]), 8'h00);
    step(5'b0, 5'b0, 1'b1);

    // full contention, back-to-back rotation
    step(5'b0, 5'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(5'b11111, 5'b11111, 1'b1);
      chk("rr_sel", 8'(s[0]), 8'(i % 5));
      chk("rr_valid", 8'(v[0]), 8'h01);
    end

    // timeout on dut1 (MAX_BURST=4)
    step(5'b0, 5'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(5'b01010, 5'b0, 1'b1);
      if (i <= 4) chk("to_hold", 8'(g[1]), 8'h02);
      if (i == 5) begin
        chk("to_next_grant", 8'(g[1]), 8'h08);
        chk("to_next_sel", 8'(s[1]), 8'h03);
        chk("to_preempt", 8'(pr[1]), 8'h01);
      end
      if (i == 6) chk("to_preempt_pulse", 8'(pr[1]), 8'h00);
    end

    // turnaround on dut2
    step(5'b0, 5'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(5'b00011, 5'b11111, 1'b1);
      chk("turn_grant", 8'(g[2]), 8'(exp_ta[i]));
    end

    // withdrawal by owner 4
    step(5'b0, 5'b0, 1'b0);
    step(5'b10000, 5'b0, 1'b1);
    step(5'b10001, 5'b0, 1'b1);
    chk("wd_owner4", 8'(g[0]), 8'h10);
    step(5'b00001, 5'b0, 1'b1);
    chk("wd_grant", 8'(g[0]), 8'h01);
    chk("wd_sel", 8'(s[0]), 8'h00);
    chk("wd_preempt", 8'(pr[0]), 8'h00);

    // reset in the middle of a burst
    step(5'b0, 5'b0, 1'b0);
    step(5'b01000, 5'b0, 1'b1);
    step(5'b01000, 5'b0, 1'b1);
    chk("mr_owner3", 8'(g[0]), 8'h08);
    step(5'b01000, 5'b0, 1'b0);
    chk("mr_grant", 8'(g[0]), 8'h00);
    chk("mr_sel", 8'(s[0]), 8'h00);
    chk("mr_valid", 8'(v[0]), 8'h00);
    step(5'b01000, 5'b0, 1'b1);
    chk("mr_regrant", 8'(g[0]), 8'h08);
    chk("mr_resel", 8'(s[0]), 8'h03);

    // randomized traffic against the model
    rr = 5'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 5'($urandom);
      rl = 5'($urandom) & 5'($urandom) & 5'($urandom);
      rn = ($urandom_range(0, 199) != 0);
      step(rr, rl, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
